// File: rtl/mem_req_sched_pkg.sv
// mem_req_sched_pkg: shared request type, issue-FSM states and default sizes for the memory request scheduler
package mem_req_sched_pkg;
  localparam int WIDTH_DEF     = 32;
  localparam int DEPTH_DEF     = 16;
  localparam int ADDRESS_DEF   = 4;
  localparam int REQ_DEPTH_DEF = 4;
  localparam int RSP_DEPTH     = 2;
  localparam int READ_CREDITS  = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;
  typedef struct packed {
    logic                   write;
    logic [ADDRESS_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]   data;
  } req_t;
endpackage

// File: rtl/mem_sched_fifo.sv
// mem_sched_fifo: synchronous FIFO; push/pop/din in, dout (0 when empty) and occupancy count out
module mem_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         empty, full, do_push, do_pop;
  // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    count   = wr_q - rd_q;
    empty   = count == '0;
    full    = count == CW'(DEPTH);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + CW'(do_push);
    rd_d    = rd_q + CW'(do_pop);
    dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mem_req_sched.sv
// mem_req_sched: in-order request queue issuing single-port memory writes/reads with credit-limited read responses
// Ports: req_* upstream request handshake; in_data/address/wr_en/rd_en to memory; out_data/valid_out from memory;
//        rsp_* downstream read response handshake; busy while requests are queued or a read is outstanding.
module mem_req_sched
  import mem_req_sched_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDRESS   = ADDRESS_DEF,
  parameter int REQ_DEPTH = REQ_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDRESS-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_data,
  output logic [WIDTH-1:0]   in_data,
  output logic [ADDRESS-1:0] address,
  output logic               wr_en,
  output logic               rd_en,
  input  logic [WIDTH-1:0]   out_data,
  input  logic               valid_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [ADDRESS-1:0] rsp_addr,
  output logic               busy
);
  localparam int QW = $clog2(REQ_DEPTH);
  localparam int SW = $clog2(RSP_DEPTH);
  typedef struct packed {
    logic               write;
    logic [ADDRESS-1:0] addr;
    logic [WIDTH-1:0]   data;
  } entry_t;
  entry_t                     push_entry, head;
  logic [QW:0]                rq_count;
  logic [SW:0]                rsp_count;
  logic [ADDRESS+WIDTH-1:0]   rsp_word;
  logic                       rq_full, rq_empty, rq_push, rq_pop, rsp_push, rsp_pop;
  logic [1:0]                 credits;
  state_e                     state;
  logic                       wr_en_q, wr_en_d, rd_en_q, rd_en_d, pend_q, pend_d;
  logic [ADDRESS-1:0]         address_q, address_d, pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0]           in_data_q, in_data_d;
  assign push_entry = {req_write, req_addr, req_data};
  mem_sched_fifo #(.W($bits(entry_t)), .DEPTH(REQ_DEPTH)) u_req_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rq_push),
    .din   (push_entry),
    .pop   (rq_pop),
    .dout  (head),
    .count (rq_count)
  );
  mem_sched_fifo #(.W(ADDRESS + WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   ({pend_addr_q, out_data}),
    .pop   (rsp_pop),
    .dout  (rsp_word),
    .count (rsp_count)
  );
  // A read holds its credit from issue until its response leaves the response FIFO:
  // rd_en_q and pend_q cover the two cycles before the response lands.
  always_comb begin
    rq_empty    = rq_count == '0;
    rq_full     = rq_count == (QW+1)'(REQ_DEPTH);
    credits     = 2'(READ_CREDITS) - (2'(rsp_count) + {1'b0, rd_en_q} + {1'b0, pend_q});
    state       = rq_empty ? ST_IDLE : (head.write || credits != 2'd0) ? ST_ISSUE : ST_HOLD;
    rq_pop      = state == ST_ISSUE;
    req_ready   = rst && (!rq_full || rq_pop);
    rq_push     = req_valid && req_ready;
    wr_en_d     = rq_pop && head.write;
    rd_en_d     = rq_pop && !head.write;
    address_d   = rq_pop ? head.addr : address_q;
    in_data_d   = wr_en_d ? head.data : in_data_q;
    pend_d      = rd_en_q;
    pend_addr_d = rd_en_q ? address_q : pend_addr_q;
    rsp_push    = valid_out && pend_q;
    rsp_valid   = rsp_count != '0;
    rsp_pop     = rsp_valid && rsp_ready;
    {rsp_addr, rsp_data} = rsp_word;
    busy        = !rq_empty || rd_en_q || pend_q;
    wr_en       = wr_en_q;
    rd_en       = rd_en_q;
    address     = address_q;
    in_data     = in_data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      pend_q      <= 1'b0;
      address_q   <= '0;
      pend_addr_q <= '0;
      in_data_q   <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      pend_q      <= pend_d;
      address_q   <= address_d;
      pend_addr_q <= pend_addr_d;
      in_data_q   <= in_data_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rst) !(wr_en_q && rd_en_q));
  assert property (@(posedge clk) disable iff (!rst) (wr_en_q || rd_en_q) |-> int'(address_q) < DEPTH);
endmodule

// File: tb/tb_mem_req_sched.sv
// tb_mem_req_sched: directed stimulus with a response scoreboard for mem_req_sched
module tb_mem_req_sched;
  import mem_req_sched_pkg::*;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid, req_ready, req_write, wr_en, rd_en, valid_out, rsp_valid, rsp_ready, busy;
  logic [3:0]  req_addr, address, rsp_addr;
  logic [31:0] req_data, in_data, out_data, rsp_data;
  logic [31:0] mem [16];
  logic [31:0] shadow [16];
  logic        vo_q, spur = 1'b0;
  logic [31:0] od_q;
  req_t        exp_q [$];
  int          checks = 0, errors = 0, cyc = 0, rd_cnt = 0;
  int          wr_cyc = -1, rd_cyc = -1, rspv_cyc = -1;
  logic        rspv_prev = 1'b0;
  mem_req_sched #(.WIDTH(32), .DEPTH(16), .ADDRESS(4), .REQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .in_data(in_data), .address(address), .wr_en(wr_en),
    .rd_en(rd_en), .out_data(out_data), .valid_out(valid_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .busy(busy)
  );
  assign valid_out = vo_q | spur;
  assign out_data  = od_q;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vo_q <= 1'b0;
      od_q <= '0;
    end else begin
      vo_q <= rd_en;
      od_q <= mem[address];
      if (wr_en) mem[address] <= in_data;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) rspv_prev = 1'b0;
    else begin
      if (wr_en || rd_en) chk("wr_rd_exclusive", {wr_en, rd_en}, wr_en ? 2'b10 : 2'b01);
      if (wr_en) wr_cyc = cyc;
      if (rd_en) begin rd_cyc = cyc; rd_cnt++; end
      if (rsp_valid && !rspv_prev) rspv_cyc = cyc;
      rspv_prev = rsp_valid;
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
        else begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_addr", rsp_addr, exp_q[0].addr);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end
  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    acc = -1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) chk("send_timeout", req_ready, 1'b1);
    else begin
      @(posedge clk); #1;
      acc = cyc;
      if (w) shadow[a] = d;
      else exp_q.push_back('{write: 1'b0, addr: a, data: shadow[a]});
    end
    req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_data"}, in_data, 0);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_addr"}, rsp_addr, 0);
  endtask
  logic [3:0]  wa [5] = '{4'd5, 4'd9, 4'd15, 4'd0, 4'd3};
  logic [31:0] wd [5] = '{32'h12345678, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000, 32'h0BADF00D};
  logic [3:0]  ra [5] = '{4'd15, 4'd0, 4'd9, 4'd5, 4'd3};
  initial begin
    int a0, a1, base, n;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst_init");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_credits", dut.credits, 2);
    chk("rel_state", dut.state, ST_IDLE);
    send(1'b1, 4'd3, 32'hDEADBEEF, a0);
    send(1'b0, 4'd3, '0, a1);
    drain();
    chk("lat_wr_en", wr_cyc, a0 + 1);
    chk("lat_rd_en", rd_cyc, a0 + 2);
    chk("lat_rsp_valid", rspv_cyc, a1 + 3);
    foreach (wa[i]) send(1'b1, wa[i], wd[i], a0);
    foreach (ra[i]) send(1'b0, ra[i], '0, a0);
    send(1'b1, 4'd7, 32'h11111111, a0);
    send(1'b0, 4'd7, '0, a0);
    send(1'b1, 4'd7, 32'h22222222, a0);
    send(1'b0, 4'd7, '0, a0);
    drain();
    rsp_ready = 1'b0;
    base = rd_cnt;
    send(1'b0, 4'd3, '0, a0);
    send(1'b0, 4'd5, '0, a0);
    send(1'b0, 4'd9, '0, a0);
    repeat (6) @(posedge clk); #1;
    chk("hold_rd_pulses", rd_cnt - base, 2);
    chk("hold_state", dut.state, ST_HOLD);
    chk("hold_credits", dut.credits, 0);
    chk("hold_rsp_valid", rsp_valid, 1);
    send(1'b0, 4'd15, '0, a0);
    send(1'b0, 4'd0, '0, a0);
    send(1'b0, 4'd7, '0, a0);
    chk("full_req_ready", req_ready, 0);
    chk("full_count", dut.rq_count, 4);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd9; req_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("held_count", dut.rq_count, 4);
    chk("held_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("pp_req_ready", req_ready, 1);
    chk("pp_count", dut.rq_count, 4);
    chk("pp_pop", dut.rq_pop, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back('{write: 1'b0, addr: 4'd9, data: shadow[9]});
    chk("pp_count_after", dut.rq_count, 4);
    drain();
    chk("all_rd_pulses", rd_cnt - base, 7);
    repeat (2) @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("spur_rsp_valid", rsp_valid, 0);
    chk("spur_credits", dut.credits, 2);
    chk("spur_busy", busy, 0);
    rsp_ready = 1'b0;
    send(1'b0, 4'd15, '0, a0);
    send(1'b0, 4'd7, '0, a0);
    send(1'b0, 4'd9, '0, a0);
    #2 rst = 1'b0;
    exp_q.delete();
    #1 chk_outputs_zero("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_credits", dut.credits, 2);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_state", dut.state, ST_IDLE);
    rsp_ready = 1'b1;
    send(1'b1, 4'd2, 32'hCAFEF00D, a0);
    send(1'b0, 4'd2, '0, a0);
    send(1'b0, 4'd9, '0, a0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
